bbox_msg_scheduler: RTL



---
 rtl/imgproc_pkg.sv | 31 +++
 rtl/bbox_msg_scheduler_if.sv | 11 +
 rtl/bbox_msg_scheduler_rr_pick.sv | 27 ++
 rtl/bbox_msg_scheduler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/imgproc_pkg.sv
// Shared image-processor definitions: scheduler FSM states, colour message IDs
// and the packing of detector results into 32-bit CPU message words.
package imgproc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_W_ID,
        ST_W_MIN,
        ST_W_MAX
    } sched_state_t;

    localparam int COORD_W = 11;

    localparam logic [23:0] ID_RED    = "RBB";
    localparam logic [23:0] ID_BLUE   = "BBB";
    localparam logic [23:0] ID_YELLOW = "YBB";
    localparam logic [23:0] ID_WHITE  = "WBB";
    localparam logic [23:0] ID_BLACK  = "KBB";

    function automatic logic [31:0] pack_id(input logic [23:0] id);
        return {8'h00, id};
    endfunction

    // {x, y} -> {pad, x, pad, y}, each coordinate in its own 16-bit half
    function automatic logic [31:0] pack_coord(input logic [2*COORD_W-1:0] xy);
        return {{(16-COORD_W){1'b0}}, xy[2*COORD_W-1:COORD_W],
                {(16-COORD_W){1'b0}}, xy[COORD_W-1:0]};
    endfunction

endpackage

// File: rtl/bbox_msg_scheduler_if.sv
// Write side of the CPU message FIFO, as seen by the bounding-box scheduler.
interface bbox_msg_scheduler_if #(
    parameter int SIZE_W = 8
);
    logic              fifo_wr;
    logic [31:0]       fifo_data;
    logic [SIZE_W-1:0] fifo_usedw;

    modport master (output fifo_wr, output fifo_data, input fifo_usedw);
    modport slave  (input fifo_wr, input fifo_data, output fifo_usedw);
endinterface

// File: rtl/bbox_msg_scheduler_rr_pick.sv
// Combinational round-robin picker: first request at or above ptr, wrapping.
module rr_pick #(
    parameter int NUM_SRC = 5,
    parameter int PW      = 3
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [PW-1:0]      idx,
    output logic               any
);
    logic [NUM_SRC-1:0] req_hi;

    always_comb begin
        req_hi = '0;
        idx    = '0;
        for (int k = 0; k < NUM_SRC; k++)
            req_hi[k] = req[k] && (k >= int'(ptr));
        // wrapped candidate first, then let any request at/above ptr override it
        for (int k = NUM_SRC-1; k >= 0; k--)
            if (req[k]) idx = PW'(k);
        for (int k = NUM_SRC-1; k >= 0; k--)
            if (req_hi[k]) idx = PW'(k);
        any   = |req;
        grant = any ? (NUM_SRC'(1) << idx) : '0;
    end
endmodule

// File: rtl/bbox_msg_scheduler.sv
// Snapshots per-colour bounding boxes at frame end and streams them as 3-word
// messages into the CPU FIFO, round-robin across colours, every MSG_INTERVAL frames.
module bbox_msg_scheduler
    import imgproc_pkg::*;
#(
    parameter int NUM_SRC      = 5,
    parameter int MSG_INTERVAL = 6,
    parameter int FIFO_DEPTH   = 256,
    parameter int SIZE_W       = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_done,
    input  logic [NUM_SRC-1:0]             src_en,
    input  logic [NUM_SRC-1:0]             src_hit,
    input  logic [NUM_SRC*24-1:0]          src_id,
    input  logic [NUM_SRC*2*COORD_W-1:0]   src_min,
    input  logic [NUM_SRC*2*COORD_W-1:0]   src_max,
    bbox_msg_scheduler_if.master           msg,
    output logic                           busy,
    output logic [15:0]                    drop_cnt
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int FW = (MSG_INTERVAL > 1) ? $clog2(MSG_INTERVAL) : 1;
    localparam int CW = $clog2(2*NUM_SRC + 1);

    sched_state_t                         state;
    logic [FW-1:0]                        fcnt;
    logic [PW-1:0]                        rr_ptr, sel;
    logic [NUM_SRC-1:0]                   pending, sel_oh;
    logic [NUM_SRC-1:0][23:0]             snap_id;
    logic [NUM_SRC-1:0][2*COORD_W-1:0]    snap_min, snap_max;

    logic                                 trig, room, pick_any;
    logic [NUM_SRC-1:0]                   pick_oh;
    logic [PW-1:0]                        pick_idx;
    logic [CW-1:0]                        drop_add;
    logic [16:0]                          drop_sum;

    function automatic logic [CW-1:0] popcnt(input logic [NUM_SRC-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_SRC; k++) c = c + CW'(v[k]);
        return c;
    endfunction

    rr_pick #(.NUM_SRC(NUM_SRC), .PW(PW)) u_pick (
        .req   (pending),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign trig = frame_done && (fcnt == '0);
    assign room = int'(msg.fifo_usedw) < FIFO_DEPTH - 3;

    // a busy-time trigger and a no-room flush can land in the same cycle
    always_comb begin
        drop_add = '0;
        if (trig && state != ST_IDLE)
            drop_add = popcnt(src_en & src_hit);
        if (state == ST_PICK && pick_any && !room)
            drop_add = drop_add + popcnt(pending);
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_add);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            fcnt          <= '0;
            rr_ptr        <= '0;
            sel           <= '0;
            sel_oh        <= '0;
            pending       <= '0;
            snap_id       <= '0;
            snap_min      <= '0;
            snap_max      <= '0;
            msg.fifo_wr   <= 1'b0;
            msg.fifo_data <= '0;
            busy          <= 1'b0;
            drop_cnt      <= '0;
        end else begin
            if (frame_done)
                fcnt <= (fcnt == '0) ? FW'(MSG_INTERVAL-1) : fcnt - 1'b1;
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            case (state)
                ST_IDLE: if (trig) begin
                    snap_id  <= src_id;
                    snap_min <= src_min;
                    snap_max <= src_max;
                    pending  <= src_en & src_hit;
                    busy     <= 1'b1;
                    state    <= ST_PICK;
                end
                ST_PICK: begin
                    if (!pick_any) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (room) begin
                        sel           <= pick_idx;
                        sel_oh        <= pick_oh;
                        msg.fifo_wr   <= 1'b1;
                        msg.fifo_data <= pack_id(snap_id[pick_idx]);
                        state         <= ST_W_ID;
                    end else begin
                        pending <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                ST_W_ID: begin
                    msg.fifo_data <= pack_coord(snap_min[sel]);
                    state         <= ST_W_MIN;
                end
                ST_W_MIN: begin
                    msg.fifo_data <= pack_coord(snap_max[sel]);
                    state         <= ST_W_MAX;
                end
                ST_W_MAX: begin
                    msg.fifo_wr   <= 1'b0;
                    msg.fifo_data <= '0;
                    pending       <= pending & ~sel_oh;
                    rr_ptr        <= (sel == PW'(NUM_SRC-1)) ? '0 : sel + 1'b1;
                    state         <= ST_PICK;
                end
                default: begin
                    msg.fifo_wr   <= 1'b0;
                    msg.fifo_data <= '0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
